// File: rtl/execute_stage_fwd.sv
// EX stage: operand forwarding, ALU with optional saturation, iterative shift-add
// multiplier with stall, N/Z/V flag register and the EX/MEM pipeline register.
module execute_stage_fwd #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_op,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              ex_stall,
    output logic              exmem_valid,
    output logic [DATA_W-1:0] exmem_result,
    output logic [REG_AW-1:0] exmem_rd_addr,
    output logic              exmem_reg_write,
    output logic [2:0]        flags_out,
    output logic [1:0]        mul_state
);
    localparam int SHW  = $clog2(DATA_W);
    localparam int CNTW = $clog2(DATA_W + 1);
    localparam int MSB  = DATA_W - 1;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3,
                           OP_OR  = 4'd4, OP_SLL = 4'd5, OP_SRA = 4'd6, OP_ROR = 4'd7,
                           OP_MUL = 4'd8, OP_PASSB = 4'd9;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [DATA_W-1:0] acc, mcand, mplier;
    logic [REG_AW-1:0] mul_rd;
    logic              mul_we;
    logic              flag_n, flag_z, flag_v;

    logic [DATA_W-1:0]   op_a, op_b, sum, diff, alu_res;
    logic [2*DATA_W-1:0] rot;
    logic [SHW-1:0]      sh;
    logic                add_ovf, sub_ovf, alu_v, upd_nv, upd_z;

    assign flags_out = {flag_n, flag_z, flag_v};
    assign mul_state = state;

    // EX/MEM is the youngest producer, so it wins over MEM/WB; r0 always reads zero.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] addr,
                                              input logic [DATA_W-1:0] rf_data);
        if (addr == '0)
            return '0;
        else if (exmem_valid && exmem_reg_write && exmem_rd_addr == addr)
            return exmem_result;
        else if (memwb_reg_write && memwb_rd_addr == addr)
            return memwb_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        op_a = fwd(id_rs1_addr, id_rs1_data);
        op_b = id_alu_src ? id_imm : fwd(id_rs2_addr, id_rs2_data);
    end

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
        sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
        sh      = op_b[SHW-1:0];
        rot     = {op_a, op_a} >> sh;
        alu_res = '0;
        alu_v   = 1'b0;
        upd_nv  = 1'b0;
        upd_z   = 1'b0;
        case (id_op)
            OP_ADD: begin
                alu_v   = add_ovf;
                alu_res = (SATURATE != 0 && add_ovf) ? (op_a[MSB] ? SAT_MIN : SAT_MAX) : sum;
                upd_nv  = 1'b1;
                upd_z   = 1'b1;
            end
            OP_SUB: begin
                alu_v   = sub_ovf;
                alu_res = (SATURATE != 0 && sub_ovf) ? (op_a[MSB] ? SAT_MIN : SAT_MAX) : diff;
                upd_nv  = 1'b1;
                upd_z   = 1'b1;
            end
            OP_XOR:   begin alu_res = op_a ^ op_b;            upd_z = 1'b1; end
            OP_AND:   begin alu_res = op_a & op_b;            upd_z = 1'b1; end
            OP_OR:    begin alu_res = op_a | op_b;            upd_z = 1'b1; end
            OP_SLL:   begin alu_res = op_a << sh;             upd_z = 1'b1; end
            OP_SRA:   begin alu_res = $signed(op_a) >>> sh;   upd_z = 1'b1; end
            OP_ROR:   begin alu_res = rot[DATA_W-1:0];        upd_z = 1'b1; end
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Stall handshake: ID holds its instruction steady while ex_stall=1 and the
    // instruction is consumed at the first edge where ex_stall=0 (and no flush).
    always_comb begin
        ex_stall = mem_stall;
        case (state)
            S_IDLE:  if (id_valid && !flush && id_op == OP_MUL) ex_stall = 1'b1;
            S_RUN:   if (!flush) ex_stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            mul_rd          <= '0;
            mul_we          <= 1'b0;
            exmem_valid     <= 1'b0;
            exmem_result    <= '0;
            exmem_rd_addr   <= '0;
            exmem_reg_write <= 1'b0;
            flag_n          <= 1'b0;
            flag_z          <= 1'b0;
            flag_v          <= 1'b0;
        end else if (mem_stall) begin
            // Downstream hold freezes everything except a flush aborting a multiply.
            if (flush && state != S_IDLE) state <= S_IDLE;
        end else begin
            exmem_valid     <= 1'b0;
            exmem_reg_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (id_valid && !flush) begin
                        if (id_op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= op_a;
                            mplier <= op_b;
                            cnt    <= '0;
                            mul_rd <= id_rd_addr;
                            mul_we <= id_reg_write;
                            state  <= S_RUN;
                        end else begin
                            exmem_valid     <= 1'b1;
                            exmem_result    <= alu_res;
                            exmem_rd_addr   <= id_rd_addr;
                            exmem_reg_write <= id_reg_write;
                            if (upd_nv) begin
                                flag_n <= alu_res[MSB];
                                flag_v <= alu_v;
                            end
                            if (upd_z) flag_z <= (alu_res == '0);
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNTW'(DATA_W - 1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        exmem_valid     <= 1'b1;
                        exmem_result    <= acc;
                        exmem_rd_addr   <= mul_rd;
                        exmem_reg_write <= mul_we;
                        flag_z          <= (acc == '0);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_stage_fwd.sv
// Directed bench for execute_stage_fwd: a saturating instance and a wrapping
// instance share the same stimulus; expected values are hand-computed.
module tb_execute_stage_fwd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_alu_src, id_reg_write, memwb_reg_write, mem_stall, flush;
    logic [3:0]  id_op, id_rs1_addr, id_rs2_addr, id_rd_addr, memwb_rd_addr;
    logic [15:0] id_rs1_data, id_rs2_data, id_imm, memwb_data;

    logic        ex_stall, exmem_valid, exmem_reg_write;
    logic [15:0] exmem_result;
    logic [3:0]  exmem_rd_addr;
    logic [2:0]  flags_out;
    logic [1:0]  mul_state;

    logic        w_ex_stall, w_exmem_valid, w_exmem_reg_write;
    logic [15:0] w_exmem_result;
    logic [3:0]  w_exmem_rd_addr;
    logic [2:0]  w_flags_out;
    logic [1:0]  w_mul_state;

    int total = 0;
    int bad   = 0;
    int stall_cycles;
    logic saw_valid;

    always #5 clk = ~clk;

    execute_stage_fwd #(.DATA_W(16), .REG_AW(4), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
        .memwb_data(memwb_data), .mem_stall(mem_stall), .flush(flush),
        .ex_stall(ex_stall), .exmem_valid(exmem_valid), .exmem_result(exmem_result),
        .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
        .flags_out(flags_out), .mul_state(mul_state)
    );

    execute_stage_fwd #(.DATA_W(16), .REG_AW(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
        .memwb_data(memwb_data), .mem_stall(mem_stall), .flush(flush),
        .ex_stall(w_ex_stall), .exmem_valid(w_exmem_valid), .exmem_result(w_exmem_result),
        .exmem_rd_addr(w_exmem_rd_addr), .exmem_reg_write(w_exmem_reg_write),
        .flags_out(w_flags_out), .mul_state(w_mul_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_op = 4'd0; id_rs1_addr = 4'd0; id_rs2_addr = 4'd0;
        id_rs1_data = 16'd0; id_rs2_data = 16'd0; id_imm = 16'd0; id_alu_src = 1'b0;
        id_rd_addr = 4'd0; id_reg_write = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] a1, input logic [15:0] d1,
                         input logic [3:0] a2, input logic [15:0] d2, input logic [3:0] rd);
        id_valid = 1'b1; id_op = op; id_rs1_addr = a1; id_rs1_data = d1;
        id_rs2_addr = a2; id_rs2_data = d2; id_imm = 16'd0; id_alu_src = 1'b0;
        id_rd_addr = rd; id_reg_write = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        memwb_rd_addr = 4'd0; memwb_reg_write = 1'b0; memwb_data = 16'd0;
        #12;
        check("rst_valid", exmem_valid, 0);
        check("rst_result", exmem_result, 0);
        check("rst_rd", exmem_rd_addr, 0);
        check("rst_we", exmem_reg_write, 0);
        check("rst_flags", flags_out, 0);
        check("rst_stall", ex_stall, 0);
        check("rst_state", mul_state, 0);
        rst_n = 1'b1;

        // Signed overflow: saturating vs wrapping
        issue(4'd0, 4'd2, 16'h7FFF, 4'd3, 16'h0001, 4'd5); step();
        check("add_pos_sat_res", exmem_result, 16'h7FFF);
        check("add_pos_sat_flags", flags_out, 3'b001);
        check("add_valid", exmem_valid, 1);
        check("add_rd", exmem_rd_addr, 5);
        check("add_we", exmem_reg_write, 1);
        check("add_pos_wrap_res", w_exmem_result, 16'h8000);
        check("add_pos_wrap_flags", w_flags_out, 3'b101);
        issue(4'd1, 4'd2, 16'h8000, 4'd3, 16'h0001, 4'd5); step();
        check("sub_neg_sat_res", exmem_result, 16'h8000);
        check("sub_neg_sat_flags", flags_out, 3'b101);
        check("sub_neg_wrap_res", w_exmem_result, 16'h7FFF);
        check("sub_neg_wrap_flags", w_flags_out, 3'b001);

        // Bubbles keep result/rd but clear valid and write enable
        idle(); step();
        check("bubble_valid", exmem_valid, 0);
        check("bubble_we", exmem_reg_write, 0);
        check("bubble_res", exmem_result, 16'h8000);
        check("bubble_flags", flags_out, 3'b101);
        issue(4'd0, 4'd2, 16'h0001, 4'd3, 16'h0001, 4'd5); flush = 1'b1; step();
        check("flush_valid", exmem_valid, 0);
        check("flush_res", exmem_result, 16'h8000);

        // Forwarding
        issue(4'd0, 4'd2, 16'd5, 4'd3, 16'd7, 4'd1); step();
        check("fwd_add_res", exmem_result, 16'h000C);
        check("fwd_add_flags", flags_out, 3'b000);
        issue(4'd1, 4'd1, 16'd0, 4'd2, 16'd5, 4'd4);
        memwb_rd_addr = 4'd1; memwb_reg_write = 1'b1; memwb_data = 16'd99; step();
        check("fwd_exmem_res", exmem_result, 16'h0007);
        issue(4'd0, 4'd1, 16'd0, 4'd0, 16'h1234, 4'd6); step();
        check("fwd_memwb_r0_res", exmem_result, 16'h0063);
        issue(4'd0, 4'd0, 16'h5555, 4'd4, 16'd0, 4'd7);
        memwb_rd_addr = 4'd4; memwb_data = 16'h0021; step();
        check("fwd_r0_a_res", exmem_result, 16'h0021);
        issue(4'd0, 4'd7, 16'd0, 4'd0, 16'd0, 4'd8);
        memwb_rd_addr = 4'd7; memwb_data = 16'h0777; step();
        check("fwd_priority_res", exmem_result, 16'h0021);
        memwb_reg_write = 1'b0;

        // Shifts, undefined op, PASSB
        issue(4'd6, 4'd2, 16'h8010, 4'd0, 16'd0, 4'd8); id_alu_src = 1'b1; id_imm = 16'h0004; step();
        check("sra_res", exmem_result, 16'hF801);
        issue(4'd7, 4'd2, 16'h1234, 4'd3, 16'h0004, 4'd8); step();
        check("ror_res", exmem_result, 16'h4123);
        issue(4'd5, 4'd2, 16'h0001, 4'd3, 16'd0, 4'd8); id_alu_src = 1'b1; id_imm = 16'h001F; step();
        check("sll_res", exmem_result, 16'h8000);
        check("sll_flags", flags_out, 3'b000);
        issue(4'hC, 4'd2, 16'h1234, 4'd3, 16'h0001, 4'd8); step();
        check("undef_res", exmem_result, 16'h0000);
        check("undef_valid", exmem_valid, 1);
        check("undef_flags", flags_out, 3'b000);
        issue(4'd9, 4'd2, 16'h0001, 4'd3, 16'd0, 4'd8); id_alu_src = 1'b1; id_imm = 16'hBEEF; step();
        check("passb_res", exmem_result, 16'hBEEF);

        // N survives a Z-only update
        issue(4'd0, 4'd2, 16'hFFFF, 4'd3, 16'h0000, 4'd8); step();
        check("add_n_flags", flags_out, 3'b100);
        issue(4'd2, 4'd2, 16'h00FF, 4'd3, 16'd0, 4'd9); id_alu_src = 1'b1; id_imm = 16'h00FF; step();
        check("xor_res", exmem_result, 16'h0000);
        check("xor_flags", flags_out, 3'b110);

        // Multiply: stall length and result
        issue(4'd8, 4'd2, 16'h0012, 4'd3, 16'h0034, 4'd10); #1;
        stall_cycles = ex_stall ? 1 : 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!ex_stall) break;
            stall_cycles++;
            if (exmem_valid) saw_valid = 1'b1;
        end
        check("mul_stall_cycles", stall_cycles, 17);
        check("mul_no_valid", saw_valid, 0);
        check("mul_done_state", mul_state, 2);
        check("mul_done_valid", exmem_valid, 0);
        step(); idle();
        check("mul_res", exmem_result, 16'h03A8);
        check("mul_valid", exmem_valid, 1);
        check("mul_rd", exmem_rd_addr, 10);
        check("mul_flags", flags_out, 3'b100);

        // Flush on the 5th RUN cycle
        issue(4'd8, 4'd2, 16'd3, 4'd3, 16'd5, 4'd11); step();
        for (int i = 0; i < 4; i++) step();
        check("mflush_run", mul_state, 1);
        flush = 1'b1; #1;
        check("mflush_stall", ex_stall, 0);
        step(); idle();
        check("mflush_state", mul_state, 0);
        check("mflush_valid", exmem_valid, 0);
        check("mflush_res", exmem_result, 16'h03A8);
        check("mflush_flags", flags_out, 3'b100);
        step();
        check("mflush_no_commit", exmem_valid, 0);

        // mem_stall freezes a valid EX/MEM entry
        issue(4'd0, 4'd2, 16'h0100, 4'd3, 16'h0200, 4'd13); step();
        check("pre_hold_res", exmem_result, 16'h0300);
        issue(4'd1, 4'd2, 16'd5, 4'd3, 16'd5, 4'd14); mem_stall = 1'b1; #1;
        check("hold_stall", ex_stall, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_res", exmem_result, 16'h0300);
            check("hold_valid", exmem_valid, 1);
            check("hold_flags", flags_out, 3'b000);
        end
        mem_stall = 1'b0; step();
        check("post_hold_res", exmem_result, 16'h0000);
        check("post_hold_flags", flags_out, 3'b010);
        check("post_hold_rd", exmem_rd_addr, 14);

        // mem_stall while MUL waits in DONE
        issue(4'd8, 4'd2, 16'd2, 4'd3, 16'd3, 4'd15); step();
        for (int i = 0; i < 16; i++) step();
        check("mdone_state", mul_state, 2);
        check("mdone_stall", ex_stall, 0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mdone_hold_state", mul_state, 2);
            check("mdone_hold_stall", ex_stall, 1);
            check("mdone_hold_valid", exmem_valid, 0);
            check("mdone_hold_flags", flags_out, 3'b010);
        end
        mem_stall = 1'b0; #1;
        check("mdone_release_stall", ex_stall, 0);
        step(); idle();
        check("mdone_res", exmem_result, 16'h0006);
        check("mdone_valid", exmem_valid, 1);
        check("mdone_rd", exmem_rd_addr, 15);
        check("mdone_flags", flags_out, 3'b000);

        // Asynchronous reset in the middle of a multiply
        issue(4'd8, 4'd2, 16'd7, 4'd3, 16'd9, 4'd5); step(); step(); step();
        #2; idle(); rst_n = 1'b0; #1;
        check("arst_valid", exmem_valid, 0);
        check("arst_res", exmem_result, 0);
        check("arst_rd", exmem_rd_addr, 0);
        check("arst_we", exmem_reg_write, 0);
        check("arst_flags", flags_out, 0);
        check("arst_stall", ex_stall, 0);
        check("arst_state", mul_state, 0);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
